// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-axis intersection controller.
// One phase FSM with a down-counting timer drives both axes' car heads and
// pedestrian signals. Phases can pause, the protected left is optional, and
// an emergency input forces all-red.
module traffic_phase_ctrl #(
  parameter int T_GREEN  = 20,
  parameter int T_LEFT   = 4,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_FLASH  = 6,
  parameter int EN_LEFT  = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_emergency,
  output logic [3:0]       o_car_a,
  output logic [3:0]       o_car_b,
  output logic [1:0]       o_wlk_a,
  output logic [1:0]       o_wlk_b,
  output logic [3:0]       o_phase,
  output logic [CNT_W-1:0] o_remain
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_GREEN  = 4'd1,
    A_LEFT   = 4'd2,
    A_YELLOW = 4'd3,
    A_CLEAR  = 4'd4,
    B_GREEN  = 4'd5,
    B_LEFT   = 4'd6,
    B_YELLOW = 4'd7,
    B_CLEAR  = 4'd8,
    EMERG    = 4'd9
  } state_e;

  // Timer reload values: a phase of T cycles counts T-1 down to 0.
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_LEFT   = CNT_W'(T_LEFT - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  // One bit wider so T_FLASH == 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0]   FLASH_TH  = (CNT_W+1)'(T_FLASH);
  localparam bit               HAS_LEFT  = (EN_LEFT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  state_e           nxt_state;
  logic [CNT_W-1:0] nxt_load;
  logic             flash_on;

  // State and timer registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Successor phase in the normal cycle and its timer reload value.
  always_comb begin
    nxt_state = EMERG;
    nxt_load  = '0;
    case (state_q)
      A_GREEN:  nxt_state = HAS_LEFT ? A_LEFT : A_YELLOW;
      A_LEFT:   nxt_state = A_YELLOW;
      A_YELLOW: nxt_state = A_CLEAR;
      A_CLEAR:  nxt_state = B_GREEN;
      B_GREEN:  nxt_state = HAS_LEFT ? B_LEFT : B_YELLOW;
      B_LEFT:   nxt_state = B_YELLOW;
      B_YELLOW: nxt_state = B_CLEAR;
      B_CLEAR:  nxt_state = A_GREEN;
      default:  nxt_state = EMERG;
    endcase
    case (nxt_state)
      A_GREEN, B_GREEN:   nxt_load = LD_GREEN;
      A_LEFT, B_LEFT:     nxt_load = LD_LEFT;
      A_YELLOW, B_YELLOW: nxt_load = LD_YELLOW;
      A_CLEAR, B_CLEAR:   nxt_load = LD_ALLRED;
      default:            nxt_load = '0;
    endcase
  end

  // Next state: emergency beats expiry; pause holds everything except
  // emergency entry and exit, which ignore i_start.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (i_emergency) begin
      state_d = EMERG;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = A_GREEN;
            timer_d = LD_GREEN;
          end
        end
        EMERG: begin
          // Leave via the B all-red so the cycle restarts cleanly at A_GREEN.
          state_d = B_CLEAR;
          timer_d = LD_ALLRED;
        end
        A_GREEN, A_LEFT, A_YELLOW, A_CLEAR,
        B_GREEN, B_LEFT, B_YELLOW, B_CLEAR: begin
          if (i_start) begin
            if (timer_q == '0) begin
              state_d = nxt_state;
              timer_d = nxt_load;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = EMERG;
          timer_d = '0;
        end
      endcase
    end
  end

  // Walk signal is steady until the last T_FLASH cycles, then blinks on timer[0].
  assign flash_on = ({1'b0, timer_q} >= FLASH_TH) || timer_q[0];

  // Moore decode of lights from the registered state and timer.
  always_comb begin
    o_car_a = 4'b1000;
    o_car_b = 4'b1000;
    o_wlk_a = 2'b10;
    o_wlk_b = 2'b10;
    case (state_q)
      IDLE: begin
        o_car_a = 4'b0000;
        o_car_b = 4'b0000;
        o_wlk_a = 2'b00;
        o_wlk_b = 2'b00;
      end
      A_GREEN: begin
        o_car_a = 4'b0001;
        o_wlk_a = flash_on ? 2'b01 : 2'b00;
      end
      A_LEFT:   o_car_a = 4'b0010;
      A_YELLOW: o_car_a = 4'b0100;
      B_GREEN: begin
        o_car_b = 4'b0001;
        o_wlk_b = flash_on ? 2'b01 : 2'b00;
      end
      B_LEFT:   o_car_b = 4'b0010;
      B_YELLOW: o_car_b = 4'b0100;
      default: ;
    endcase
  end

  assign o_phase  = state_q;
  assign o_remain = timer_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: two instances (left phases on / off) share
// the stimulus. The model unrolls one full period into a schedule table and
// just walks a position through it; outputs are looked up from phase codes.
module tb_traffic_phase_ctrl;
  localparam int TG = 20, TL = 4, TY = 3, TA = 2, TF = 6;

  logic clk = 1'b0;
  logic reset_n, i_start, i_emergency;
  logic [3:0] car_a [2];
  logic [3:0] car_b [2];
  logic [1:0] wlk_a [2];
  logic [1:0] wlk_b [2];
  logic [3:0] ph    [2];
  logic [7:0] rem   [2];

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.EN_LEFT(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_emergency(i_emergency),
    .o_car_a(car_a[0]), .o_car_b(car_b[0]), .o_wlk_a(wlk_a[0]), .o_wlk_b(wlk_b[0]),
    .o_phase(ph[0]), .o_remain(rem[0]));

  traffic_phase_ctrl #(.EN_LEFT(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_emergency(i_emergency),
    .o_car_a(car_a[1]), .o_car_b(car_b[1]), .o_wlk_a(wlk_a[1]), .o_wlk_b(wlk_b[1]),
    .o_phase(ph[1]), .o_remain(rem[1]));

  typedef struct packed {
    logic [3:0] ph;
    logic [7:0] rem;
  } ent_t;

  ent_t sch [2][64];
  int   len [2];
  int   bclr[2];
  int   mode[2];   // 0 idle, 1 running, 2 emergency
  int   pos [2];
  logic [15:0] seen[2];
  int   nvec = 0, nerr = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h want %0h (t=%0t)", nm, m, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_phase(input int m);
    if (mode[m] == 0) return 4'd0;
    if (mode[m] == 2) return 4'd9;
    return sch[m][pos[m]].ph;
  endfunction

  function automatic logic [7:0] m_rem(input int m);
    if (mode[m] != 1) return 8'd0;
    return sch[m][pos[m]].rem;
  endfunction

  // g = green code of the axis (1 for A, 5 for B).
  function automatic logic [3:0] car_of(input logic [3:0] p, input logic [3:0] g);
    if (p == 4'd0)   return 4'b0000;
    if (p == g)      return 4'b0001;
    if (p == g + 1)  return 4'b0010;
    if (p == g + 2)  return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic [1:0] wlk_of(input logic [3:0] p, input logic [3:0] g, input logic [7:0] r);
    if (p == 4'd0) return 2'b00;
    if (p != g)    return 2'b10;
    return (r >= 8'(TF) || r[0]) ? 2'b01 : 2'b00;
  endfunction

  task automatic build();
    int codes[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int durs [8] = '{TG, TL, TY, TA, TG, TL, TY, TA};
    for (int m = 0; m < 2; m++) begin
      len[m] = 0;
      for (int k = 0; k < 8; k++) begin
        if (m == 1 && (codes[k] == 2 || codes[k] == 6)) continue;
        if (codes[k] == 8) bclr[m] = len[m];
        for (int r = durs[k] - 1; r >= 0; r--) begin
          sch[m][len[m]].ph  = 4'(codes[k]);
          sch[m][len[m]].rem = 8'(r);
          len[m]++;
        end
      end
      mode[m] = 0; pos[m] = 0; seen[m] = '0;
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (!reset_n)               begin mode[m] = 0; pos[m] = 0; end
      else if (i_emergency)       mode[m] = 2;
      else if (mode[m] == 0)      begin if (i_start) begin mode[m] = 1; pos[m] = 0; end end
      else if (mode[m] == 2)      begin mode[m] = 1; pos[m] = bclr[m]; end
      else if (i_start)           pos[m] = (pos[m] + 1) % len[m];
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always begin
    @(negedge clk);
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        logic [3:0] p;
        logic [7:0] r;
        p = m_phase(m);
        r = m_rem(m);
        seen[m][ph[m]] = 1'b1;
        chk("phase",  m, 32'(ph[m]),    32'(p));
        chk("remain", m, 32'(rem[m]),   32'(r));
        chk("car_a",  m, 32'(car_a[m]), 32'(car_of(p, 4'd1)));
        chk("car_b",  m, 32'(car_b[m]), 32'(car_of(p, 4'd5)));
        chk("wlk_a",  m, 32'(wlk_a[m]), 32'(wlk_of(p, 4'd1, r)));
        chk("wlk_b",  m, 32'(wlk_b[m]), 32'(wlk_of(p, 4'd5, r)));
        chk("conflict", m,
            32'(car_a[m] != 4'b1000 && car_b[m] != 4'b1000 &&
                car_a[m] != 4'b0000 && car_b[m] != 4'b0000), 32'd0);
      end
    end
  end

  initial begin
    build();
    reset_n = 1'b0; i_start = 1'b0; i_emergency = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    // Reset state literals.
    chk("rst_phase", 0, 32'(ph[0]), 32'd0);
    chk("rst_car",   0, 32'({car_a[0], car_b[0]}), 32'h00);
    chk("rst_wlk",   0, 32'({wlk_a[0], wlk_b[0]}), 32'h0);
    chk("rst_rem",   0, 32'(rem[0]), 32'd0);

    reset_n = 1'b1;
    cyc(3);
    chk("idle_hold", 0, 32'(ph[0]), 32'd0);

    // Start: A_GREEN with 19 remaining, then check both periods.
    i_start = 1'b1;
    cyc(1);
    chk("start_ph",  0, 32'({ph[0], rem[0]}), 32'h113);
    cyc(50);
    chk("period50",  1, 32'({ph[1], rem[1]}), 32'h113);
    cyc(8);
    chk("period58",  0, 32'({ph[0], rem[0]}), 32'h113);
    // Flash window: remain 5 -> walk on, remain 4 -> walk off.
    cyc(14);
    chk("flash_r5",  0, 32'({rem[0], 6'd0, wlk_a[0]}), {8'd5, 6'd0, 2'b01});
    cyc(1);
    chk("flash_r4",  0, 32'({rem[0], 6'd0, wlk_a[0]}), {8'd4, 6'd0, 2'b00});

    // Pause in B_GREEN at remain 10.
    cyc(23);
    chk("pre_pause", 0, 32'({ph[0], rem[0]}), 32'h50A);
    i_start = 1'b0;
    cyc(7);
    chk("paused",    0, 32'({ph[0], rem[0], car_b[0]}), 32'h50A1);
    i_start = 1'b1;
    cyc(1);
    chk("resume",    0, 32'({ph[0], rem[0]}), 32'h509);
    cyc(9);
    chk("bg_last",   0, 32'({ph[0], rem[0]}), 32'h500);
    cyc(1);
    chk("bg_end",    0, 32'(ph[0]), 32'd6);

    // Emergency during A_LEFT.
    cyc(30);
    chk("in_left",   0, 32'({ph[0], rem[0]}), 32'h202);
    i_emergency = 1'b1;
    cyc(1);
    chk("emerg",     0, 32'({ph[0], car_a[0], car_b[0], wlk_a[0], wlk_b[0]}), {4'd9, 4'b1000, 4'b1000, 2'b10, 2'b10});
    cyc(4);
    i_emergency = 1'b0;
    cyc(1);
    chk("em_exit",   0, 32'({ph[0], rem[0]}), 32'h801);
    cyc(2);
    chk("em_resume", 0, 32'({ph[0], rem[0]}), 32'h113);

    // Re-assert during the recovery B_CLEAR.
    i_emergency = 1'b1; cyc(1);
    i_emergency = 1'b0; cyc(1);
    i_emergency = 1'b1; cyc(1);
    chk("em_reenter", 0, 32'(ph[0]), 32'd9);
    i_emergency = 1'b0; cyc(3);
    chk("em_again",  0, 32'({ph[0], rem[0]}), 32'h113);

    // Emergency while paused; exit does not need i_start, clear then holds.
    i_start = 1'b0; i_emergency = 1'b1; cyc(1);
    i_emergency = 1'b0; cyc(3);
    chk("em_paused", 0, 32'({ph[0], rem[0]}), 32'h801);
    i_start = 1'b1; cyc(2);
    chk("em_p_res",  0, 32'({ph[0], rem[0]}), 32'h113);

    // Reset in B_YELLOW.
    cyc(53);
    chk("in_byel",   0, 32'(ph[0]), 32'd7);
    reset_n = 1'b0; cyc(1);
    chk("rst_mid",   0, 32'({ph[0], rem[0], car_a[0], car_b[0]}), 32'h0);
    reset_n = 1'b1; i_start = 1'b0; cyc(3);
    chk("rst_idle",  0, 32'(ph[0]), 32'd0);
    i_start = 1'b1; cyc(1);
    chk("rst_start", 0, 32'({ph[0], rem[0]}), 32'h113);

    // Expiry and emergency in the same cycle: emergency wins.
    cyc(19);
    chk("exp_last",  0, 32'({ph[0], rem[0]}), 32'h100);
    i_emergency = 1'b1; cyc(1);
    chk("exp_emerg", 0, 32'(ph[0]), 32'd9);
    i_emergency = 1'b0;

    // Randomised tail, checked by the model only.
    for (int i = 0; i < 300; i++) begin
      i_start     = ($urandom_range(0, 9) != 0);
      i_emergency = ($urandom_range(0, 29) == 0);
      reset_n     = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    reset_n = 1'b1; i_start = 1'b1; i_emergency = 1'b0;
    cyc(60);

    chk("left_seen",   0, 32'({seen[0][2], seen[0][6]}), 32'h3);
    chk("no_left_seen", 1, 32'({seen[1][2], seen[1][6]}), 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised two-axis intersection controller: axis A (E/W) and axis B (S/N).
One shared phase FSM with a down-counting phase timer replaces per-approach free-running cycle counters with hard-coded offsets.
Adds configurable phase durations, an optional protected-left phase, a flashing pedestrian clearance window, a pause/run control, and an emergency all-red override.
Light encodings match the existing traffic blocks, so the block drops into the top-level in place of the four per-approach instances.

Parameters:
T_GREEN, 20, cycles of green per axis (>=1, >=T_FLASH)
T_LEFT, 4, cycles of protected-left per axis (>=1)
T_YELLOW, 3, cycles of yellow per axis (>=1)
T_ALLRED, 2, cycles of all-red clearance after each yellow and after emergency exit (>=1)
T_FLASH, 6, final cycles of green during which the pedestrian signal flashes (0..T_GREEN)
EN_LEFT, 1, 1 includes the LEFT phases; 0 skips them
CNT_W, 8, timer width; every T_* value must be <= 2^CNT_W

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
i_start  in  1  run enable; 0 = pause (state and timer hold)
i_emergency  in  1  level; 1 = force all-red
o_car_a  out  4  axis A car heads: 0001 green, 0010 left, 0100 yellow, 1000 red, 0000 dark
o_car_b  out  4  axis B car heads, same encoding
o_wlk_a  out  2  pedestrians parallel to axis A: 01 green, 10 red, 00 dark
o_wlk_b  out  2  pedestrians parallel to axis B, same encoding
o_phase  out  4  current state code
o_remain  out  CNT_W  phase timer value (cycles left minus 1)

Behaviour:
- Clock and reset: clock clk; reset reset_n, synchronous, active-low.
- Reset: state IDLE, timer 0. Outputs: o_car_a = o_car_b = 0000, o_wlk_a = o_wlk_b = 00, o_phase = 0, o_remain = 0. Reset has priority over all other inputs, including mid-phase.
- State codes:
  - IDLE = 0, A_GREEN = 1, A_LEFT = 2, A_YELLOW = 3, A_CLEAR = 4
  - B_GREEN = 5, B_LEFT = 6, B_YELLOW = 7, B_CLEAR = 8, EMERG = 9
  - Codes 10..15 are illegal; an illegal code goes to EMERG on the next cycle.
- Outputs are a Moore decode of the registered state and timer. They change on the same edge as the state, with no extra latency.
- Cycle order: A_GREEN -> A_LEFT -> A_YELLOW -> A_CLEAR -> B_GREEN -> B_LEFT -> B_YELLOW -> B_CLEAR -> A_GREEN.
- With EN_LEFT = 0, X_GREEN goes directly to X_YELLOW.
- Timer: on entry to phase P, the timer loads T_P - 1. Each cycle with i_start = 1 and i_emergency = 0:
  - timer == 0: advance to the next phase;
  - otherwise: decrement the timer.
  - Each phase therefore lasts exactly T_P enabled cycles. Default full period is 58 cycles (50 with EN_LEFT = 0).
- IDLE: outputs dark. First cycle sampled with i_start = 1 enters A_GREEN with timer = T_GREEN - 1.
- Pause: while i_start = 0, state, timer and all outputs hold, including the flash phase. Resuming continues from the held timer value.
- Light decode:
  - A_GREEN: car_a 0001.
  - A_LEFT: car_a 0010.
  - A_YELLOW: car_a 0100.
  - All other states: car_a 1000, except IDLE, where it is 0000.
  - car_b is symmetric for the B states.
- Pedestrian decode:
  - wlk_a is 01 during A_GREEN while timer >= T_FLASH.
  - While timer < T_FLASH, wlk_a is 01 if timer[0] = 1 and 00 if timer[0] = 0.
  - wlk_a is 10 in every other non-IDLE state, and 00 in IDLE.
  - wlk_b is symmetric for B_GREEN.
- Emergency:
  - i_emergency = 1 sampled in any non-reset state, including IDLE and paused states, means the next state is EMERG.
  - EMERG: all cars 1000, all walkers 10, timer 0.
  - First cycle sampled with i_emergency = 0 enters B_CLEAR with timer = T_ALLRED - 1. The cycle then resumes at A_GREEN.
  - i_emergency = 1 re-asserted during that B_CLEAR returns to EMERG.
- Simultaneous events: when a phase expires in the same cycle that i_emergency = 1, EMERG wins.
- Invariant: there is never a cycle in which car_a and car_b are both non-red while both are non-dark. The bench asserts this every cycle.

Test Plan:
- Defaults; reset then i_start = 1 held -> car_a 0001 x20, 0010 x4, 0100 x3, 1000 x2, then car_b repeats the same; car_b = 1000 while A is active; o_phase 1..8; period 58 cycles.
- A_GREEN flash -> wlk_a = 01 while o_remain is 19..6; then for o_remain 5,4,3,2,1,0, wlk_a = 01,00,01,00,01,00; wlk_b = 10 throughout.
- i_start = 0 for 7 cycles at B_GREEN, o_remain = 10 -> all outputs frozen and o_remain stays 10; after resume, the next value is 9 and B_GREEN ends 10 cycles later.
- i_emergency = 1 for 5 cycles during A_LEFT -> next cycle o_phase 9, cars 1000, walkers 10; after release, B_CLEAR for 2 cycles, then A_GREEN with o_remain = 19.
- EN_LEFT = 0 -> phase sequence 1,3,4,5,7,8; period 50 cycles; phase codes 2 and 6 never appear.
- reset_n = 0 in B_YELLOW -> next cycle IDLE, cars 0000, walkers 00, o_remain 0; with i_start = 0 held, the block stays in IDLE; asserting i_start enters A_GREEN.
